// File: rtl/div.sv
// Sequential restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN for two's complement operands.
module div #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             accept;
  logic             last;

`ifdef DIV_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  always_comb begin
    a_mag = A[WIDTH-1] ? ('0 - A) : A;
    b_mag = B[WIDTH-1] ? ('0 - B) : B;
  end
`else
  always_comb begin
    a_mag = A;
    b_mag = B;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    shl     = {rem_q, quo_q[WIDTH-1]};
    diff    = shl - {1'b0, dvs_q};
    accept  = start && (state_q != CALC);
    last    = (cnt_q == CW'(WIDTH - 1));

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (accept) begin
          if (B == '0) begin
            // Zero divisor skips iteration entirely.
            state_d = DONE;
            q_d     = '1;
            r_d     = A;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
`ifdef DIV_SIGNED_EN
            qneg_d  = A[WIDTH-1] ^ B[WIDTH-1];
            rneg_d  = A[WIDTH-1];
`endif
          end
        end
      end
      CALC: begin
        rem_d = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
          q_d     = qneg_q ? ('0 - quo_d) : quo_d;
          r_d     = rneg_q ? ('0 - rem_d) : rem_d;
`else
          q_d     = quo_d;
          r_d     = rem_d;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div.sv
// Directed and random checks of div against an arithmetic model.
// Signed cases are exercised when DIV_SIGNED_EN is defined.
module tb_div;

  logic        CLK;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] Q;
  logic [31:0] R;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  div #(.WIDTH(32)) dut (
    .CLK(CLK),
    .rst(rst),
    .start(start),
    .A(A),
    .B(B),
    .busy(busy),
    .done(done),
    .Q(Q),
    .R(R),
    .div_by_zero(div_by_zero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q,
                                output logic [31:0] r,
                                output logic z);
`ifdef DIV_SIGNED_EN
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
`endif
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      q = 32'(sa / sb);
      r = 32'(sa % sb);
`else
      q = a / b;
      r = a % b;
`endif
      z = 1'b0;
    end
  endfunction

  // Pulses start for one edge, then waits for done.
  // lat counts edges from the accept edge (inclusive) to done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int nbusy);
    A     = a;
    B     = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input logic [31:0] a,
                          input logic [31:0] b);
    int lat;
    int nb;
    logic [31:0] eq;
    logic [31:0] er;
    logic ez;
    model(a, b, eq, er, ez);
    run_op(a, b, lat, nb);
    chk({tag, "_lat"}, 64'(lat), (b == 0) ? 64'd1 : 64'd33);
    chk({tag, "_q"}, 64'(Q), 64'(eq));
    chk({tag, "_r"}, 64'(R), 64'(er));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
  endtask

  initial begin
    int lat;
    int nb;
    int dcnt;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] eq;
    logic [31:0] er;
    logic ez;

    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_q", 64'(Q), 64'd0);
    chk("rst_r", 64'(R), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    tick();

    // 100 / 7
    run_op(32'd100, 32'd7, lat, nb);
    chk("b7_lat", 64'(lat), 64'd33);
    chk("b7_busy_cycles", 64'(nb), 64'd32);
    chk("b7_q", 64'(Q), 64'd14);
    chk("b7_r", 64'(R), 64'd2);
    chk("b7_dbz", 64'(div_by_zero), 64'd0);
    tick();
    chk("done_pulse", 64'(done), 64'd0);
    chk("hold_q", 64'(Q), 64'd14);

    // Divide by zero
    run_op(32'd5, 32'd0, lat, nb);
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_busy_cycles", 64'(nb), 64'd0);
    chk("dz_busy", 64'(busy), 64'd0);
    chk("dz_q", 64'(Q), 64'hFFFF_FFFF);
    chk("dz_r", 64'(R), 64'd5);
    chk("dz_dbz", 64'(div_by_zero), 64'd1);
    tick();

    // Start held through CALC; re-accepted in DONE
    A     = 32'hFFFF_FFFF;
    B     = 32'd1;
    start = 1'b1;
    tick();
    A   = 32'd9;
    B   = 32'd3;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 10) chk("bb_hold_q", 64'(Q), 64'hFFFF_FFFF);
      tick();
      lat++;
    end
    chk("bb1_lat", 64'(lat), 64'd33);
`ifdef DIV_SIGNED_EN
    chk("bb1_q", 64'(Q), 64'hFFFF_FFFF);
`else
    chk("bb1_q", 64'(Q), 64'hFFFF_FFFF);
`endif
    chk("bb1_r", 64'(R), 64'd0);
    tick();
    start = 1'b0;
    chk("bb2_busy", 64'(busy), 64'd1);
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    chk("bb2_lat", 64'(lat), 64'd33);
    chk("bb2_q", 64'(Q), 64'd3);
    chk("bb2_r", 64'(R), 64'd0);
    tick();

    // Reset at iteration 10 aborts the operation
    A     = 32'd1000;
    B     = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab_busy", 64'(busy), 64'd0);
    chk("ab_done", 64'(done), 64'd0);
    chk("ab_q", 64'(Q), 64'd0);
    chk("ab_r", 64'(R), 64'd0);
    chk("ab_dbz", 64'(div_by_zero), 64'd0);
    dcnt = 0;
    repeat (40) begin
      if (done || busy) dcnt++;
      tick();
    end
    chk("ab_no_done", 64'(dcnt), 64'd0);
    check_op("re", 32'd1000, 32'd3);
    chk("re_q333", 64'(Q), 64'd333);
    chk("re_r1", 64'(R), 64'd1);
    tick();

    // Reset wins over start
    rst   = 1'b1;
    start = 1'b1;
    A     = 32'd50;
    B     = 32'd0;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("prio_busy", 64'(busy), 64'd0);
    chk("prio_done", 64'(done), 64'd0);
    chk("prio_dbz", 64'(div_by_zero), 64'd0);
    tick();

`ifdef DIV_SIGNED_EN
    check_op("s_m7_2", 32'hFFFF_FFF9, 32'd2);
    chk("s_m7_2_q", 64'(Q), 64'hFFFF_FFFD);
    chk("s_m7_2_r", 64'(R), 64'hFFFF_FFFF);
    check_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF);
    chk("s_min_m1_q", 64'(Q), 64'h8000_0000);
    chk("s_min_m1_r", 64'(R), 64'd0);
    check_op("s_dz", 32'hFFFF_FFF0, 32'd0);
    tick();
`endif

    // Random back-to-back operations
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 15))
        0:       rb = 32'd0;
        1, 2, 3: rb = $urandom_range(1, 255);
        4:       rb = ra;
        5:       rb = 32'd1;
        default: rb = $urandom;
      endcase
      if (rb == 32'd0 && $urandom_range(0, 1) == 0) rb = 32'd7;
      model(ra, rb, eq, er, ez);
      run_op(ra, rb, lat, nb);
      checks++;
      assert (lat == ((rb == 0) ? 1 : 33) && Q === eq && R === er &&
              div_by_zero === ez) else begin
        errors++;
        $error("FAIL rnd %0d: A=%0h B=%0h got Q=%0h R=%0h z=%0b lat=%0d expected Q=%0h R=%0h z=%0b",
               i, ra, rb, Q, R, div_by_zero, lat, eq, er, ez);
      end
`ifndef DIV_SIGNED_EN
      if (rb != 32'd0) begin
        checks++;
        assert ((64'(Q) * 64'(rb) + 64'(R)) == 64'(ra) && R < rb) else begin
          errors++;
          $error("FAIL rnd_ident %0d: A=%0h B=%0h Q=%0h R=%0h", i, ra, rb,
                 Q, R);
        end
      end
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
